btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
Front end for the toggle switch block. Converts a raw, bouncing, asynchronous push-button input into a clean debounced level. On each accepted press it emits a single-cycle enable pulse that drives the switch's i_en. It also emits a release pulse for future long-press and hold logic.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples required to accept a level change; legal range 2..2^16; silicon builds override to roughly 10 ms worth of cycles.
SYNC_STAGES, 2, synchronizer flop depth; legal range 2..4.

Ports:
clk  input  1  system clock; all state updates on rising edge
i_arst_n  input  1  asynchronous active-low reset
i_sclr  input  1  synchronous clear, active high
i_btn  input  1  raw button, asynchronous to clk, active high
o_level  output  1  debounced button level, registered
o_en  output  1  one-cycle pulse on accepted press; connects to switch i_en
o_release  output  1  one-cycle pulse on accepted release

Behaviour:
- Reset: i_arst_n low clears asynchronously: synchronizer flops, counter, FSM (to IDLE), o_level, o_en and o_release all go to 0.
- Release of i_arst_n takes effect at the next clk edge.
- Synchronizer: i_btn passes through SYNC_STAGES flops to give btn_s. Only btn_s feeds the logic.
- i_sclr: highest synchronous priority.
  - Forces FSM to IDLE, counter to 0, and all outputs to 0 at the next edge.
  - Does not clear the synchronizer.
  - Suppresses any pulse that would otherwise fire on that edge.
- Counter width: CNT_W = clog2(DEBOUNCE_CYCLES+1), local constant. The counter never wraps; it holds at the terminal value.
- FSM states:
  - IDLE, o_level=0:
    - btn_s=1: go to PRESS_WAIT with cnt=1.
    - Otherwise: stay, cnt=0.
  - PRESS_WAIT, o_level=0:
    - btn_s=0: go to IDLE, cnt=0. Bounce rejected, no pulse.
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED. Set o_level=1 and o_en=1 for exactly one cycle.
    - Otherwise: cnt++.
  - PRESSED, o_level=1:
    - btn_s=0: go to RELEASE_WAIT with cnt=1.
    - Otherwise: stay, cnt=0.
  - RELEASE_WAIT, o_level=1:
    - btn_s=1: go to PRESSED, cnt=0. No pulse.
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE. Set o_level=0 and o_release=1 for exactly one cycle.
    - Otherwise: cnt++.
- Latency: let edge k be the first edge at which i_btn is sampled high, with the input stable afterwards.
  - o_en and o_level rise at edge k+(SYNC_STAGES-1)+DEBOUNCE_CYCLES. With defaults this is edge k+5.
  - Release has symmetric latency.
- Pulse width: o_en and o_release are never high for more than one cycle and are never high together.
- Held button: only one o_en per press, regardless of how long the button is held.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
- Reset mid-operation: asynchronous reset or i_sclr during PRESS_WAIT or RELEASE_WAIT discards the partial count. If the button is still held after a clear, the press is re-debounced from IDLE and o_en fires again.

Decomposition:
- State encodings (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3) go as defines in a shared header, btn_defs.v. The future long-press block reuses them.
- One sub-module, sync_ff: an N-stage synchronizer with async active-low reset, parameter STAGES.
- Counter and FSM stay in btn_debounce.

Test Plan:
1. Reset and clean press (CLK_PERIOD=10): assert i_arst_n=0, release it, then set i_btn=1 just after edge k.
   - o_en=0 at edges k+1..k+4.
   - At edge k+5+#1: o_en=1 and o_level=1.
   - At edge k+6: o_en=0 and o_level=1.
2. Bounce rejection: i_btn pattern 1,0,1,0,1 with each value held one cycle, then 0.
   - o_en and o_level stay 0 throughout; FSM returns to IDLE.
3. Held button: i_btn=1 for 40 cycles.
   - Exactly one o_en pulse; o_level stays 1.
   - Release then gives o_release=1 for one cycle, DEBOUNCE_CYCLES+1 edges after the i_btn fall.
4. Release bounce: while PRESSED, i_btn drops to 0 for 2 cycles, then returns to 1.
   - No o_release; o_level stays 1.
5. Clears mid-debounce:
   - i_sclr=1 for one cycle while in PRESS_WAIT with cnt=2: next edge gives o_level=0 and no pulse. With i_btn still 1, o_en fires DEBOUNCE_CYCLES edges after i_sclr drops.
   - i_arst_n=0 mid-PRESSED: o_level=0 immediately, before the next edge.
6. System check with switch chained (o_en to i_en):
   - First press then release gives o_sw=1.
   - Second press gives o_sw=0.
   - A bounce-only burst leaves o_sw unchanged.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: debouncer FSM state type built on the shared encodings.
package btn_debounce_pkg;
`include "btn_defs.v"
   typedef enum logic [1:0] {
      IDLE         = `BTN_IDLE,
      PRESS_WAIT   = `BTN_PRESS_WAIT,
      PRESSED      = `BTN_PRESSED,
      RELEASE_WAIT = `BTN_RELEASE_WAIT
   } state_t;
endpackage

// File: rtl/btn_defs.v
// btn_defs: state encodings shared by the debouncer and the long-press logic.
`ifndef BTN_DEFS_V
`define BTN_DEFS_V
`define BTN_IDLE         2'd0
`define BTN_PRESS_WAIT   2'd1
`define BTN_PRESSED      2'd2
`define BTN_RELEASE_WAIT 2'd3
`endif

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep synchronizer with asynchronous active-low reset.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) ff <= '0;
      else         ff <= {ff[STAGES-2:0], d};
   assign q = ff[STAGES-1];
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces a push-button, emitting press and release pulses.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic i_arst_n,
   input  logic i_sclr,
   input  logic i_btn,
   output logic o_level,
   output logic o_en,
   output logic o_release
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             btn_s;
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .arst_n (i_arst_n),
      .d      (i_btn),
      .q      (btn_s)
   );
   // The counter only advances below LAST, so it can never wrap.
   always_ff @(posedge clk or negedge i_arst_n)
      if (!i_arst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         o_level   <= 1'b0;
         o_en      <= 1'b0;
         o_release <= 1'b0;
      end else if (i_sclr) begin
         state     <= IDLE;
         cnt       <= '0;
         o_level   <= 1'b0;
         o_en      <= 1'b0;
         o_release <= 1'b0;
      end else begin
         o_en      <= 1'b0;
         o_release <= 1'b0;
         case (state)
            IDLE: begin
               state <= btn_s ? PRESS_WAIT : IDLE;
               cnt   <= btn_s ? ONE : '0;
            end
            PRESS_WAIT:
               if (!btn_s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state   <= PRESSED;
                  cnt     <= '0;
                  o_level <= 1'b1;
                  o_en    <= 1'b1;
               end else cnt <= cnt + ONE;
            PRESSED: begin
               state <= btn_s ? PRESSED : RELEASE_WAIT;
               cnt   <= btn_s ? '0 : ONE;
            end
            RELEASE_WAIT:
               if (btn_s) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  o_level   <= 1'b0;
                  o_release <= 1'b1;
               end else cnt <= cnt + ONE;
         endcase
      end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed stimulus with a pulse scoreboard checked by an independent monitor.
module tb_btn_debounce;
   localparam int DEB = 4;
   localparam int SYNC = 2;
   localparam int LAT = SYNC - 1 + DEB;
   typedef struct {bit rel; int at;} ev_t;
   logic clk = 0, i_arst_n = 0, i_sclr = 0, i_btn = 0;
   logic o_level, o_en, o_release;
   logic sw;
   int cyc = 0, checks = 0, errors = 0;
   ev_t q[$];
   ev_t mon_e;
   btn_debounce #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .i_arst_n  (i_arst_n),
      .i_sclr    (i_sclr),
      .i_btn     (i_btn),
      .o_level   (o_level),
      .o_en      (o_en),
      .o_release (o_release)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Stand-in for the downstream toggle switch driven by o_en.
   always @(posedge clk or negedge i_arst_n)
      if (!i_arst_n) sw <= 1'b0;
      else if (o_en) sw <= ~sw;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic expect_ev(input bit rel, input int at);
      ev_t e;
      e.rel = rel;
      e.at  = at;
      q.push_back(e);
   endtask
   always @(negedge clk) begin
      if (o_en && o_release) chk("pulse_overlap", 1, 0);
      else if (o_en || o_release) begin
         if (q.size() == 0) chk(o_en ? "extra_en" : "extra_release", 1, 0);
         else begin
            mon_e = q.pop_front();
            chk("pulse_kind", {31'd0, o_release}, {31'd0, mon_e.rel});
            chk("pulse_edge", cyc, mon_e.at);
            chk("pulse_level", {31'd0, o_level}, {31'd0, !mon_e.rel});
         end
      end
   end
   initial begin
      step(2);
      chk("rst_level", o_level, 0);
      chk("rst_en", o_en, 0);
      chk("rst_release", o_release, 0);
      i_arst_n = 1;
      step(2);
      // clean press: first sampling edge is cyc+1
      i_btn = 1;
      expect_ev(0, cyc + 1 + LAT);
      step(LAT);
      chk("pre_rise_en", o_en, 0);
      chk("pre_rise_level", o_level, 0);
      step(1);
      chk("rise_en", o_en, 1);
      chk("rise_level", o_level, 1);
      step(1);
      chk("after_rise_en", o_en, 0);
      chk("after_rise_level", o_level, 1);
      i_btn = 0;
      expect_ev(1, cyc + 1 + LAT);
      step(LAT + 2);
      chk("released_level", o_level, 0);
      // bounce rejection
      for (int i = 0; i < 5; i++) begin
         i_btn = (i % 2 == 0);
         step(1);
         chk("bounce_level", o_level, 0);
      end
      i_btn = 0;
      step(6);
      chk("bounce_level_end", o_level, 0);
      chk("bounce_state_idle", dut.state, 0);
      // held button
      i_btn = 1;
      expect_ev(0, cyc + 1 + LAT);
      step(40);
      chk("held_level", o_level, 1);
      i_btn = 0;
      expect_ev(1, cyc + 1 + LAT);
      step(LAT + 2);
      // release bounce
      i_btn = 1;
      expect_ev(0, cyc + 1 + LAT);
      step(LAT + 3);
      i_btn = 0;
      step(2);
      i_btn = 1;
      step(10);
      chk("rel_bounce_level", o_level, 1);
      chk("rel_bounce_state", dut.state, 2);
      i_btn = 0;
      expect_ev(1, cyc + 1 + LAT);
      step(LAT + 2);
      // synchronous clear in PRESS_WAIT with cnt=2
      i_btn = 1;
      step(SYNC + 2);
      chk("sclr_pre_state", dut.state, 1);
      chk("sclr_pre_cnt", dut.cnt, 2);
      i_sclr = 1;
      step(1);
      i_sclr = 0;
      chk("sclr_level", o_level, 0);
      chk("sclr_state", dut.state, 0);
      expect_ev(0, cyc + DEB);
      step(DEB + 2);
      chk("sclr_redebounce_level", o_level, 1);
      // async reset mid-PRESSED, button still held
      #2 i_arst_n = 0;
      #1 chk("arst_immediate_level", o_level, 0);
      @(posedge clk);
      #1 i_arst_n = 1;
      expect_ev(0, cyc + 1 + LAT);
      step(LAT + 2);
      chk("arst_redebounce_level", o_level, 1);
      i_btn = 0;
      expect_ev(1, cyc + 1 + LAT);
      step(LAT + 2);
      // system check with the toggle switch
      i_arst_n = 0;
      #2 i_arst_n = 1;
      step(2);
      chk("sys_sw_reset", sw, 0);
      i_btn = 1;
      expect_ev(0, cyc + 1 + LAT);
      step(LAT + 3);
      i_btn = 0;
      expect_ev(1, cyc + 1 + LAT);
      step(LAT + 3);
      chk("sys_sw_first", sw, 1);
      i_btn = 1;
      expect_ev(0, cyc + 1 + LAT);
      step(LAT + 3);
      chk("sys_sw_second", sw, 0);
      for (int i = 0; i < 4; i++) begin
         i_btn = (i % 2 == 1);
         step(1);
      end
      i_btn = 0;
      step(DEB - 2);
      i_btn = 1;
      step(8);
      chk("sys_sw_bounce", sw, 0);
      chk("sys_level_bounce", o_level, 1);
      i_btn = 0;
      expect_ev(1, cyc + 1 + LAT);
      step(LAT + 3);
      chk("queue_drained", q.size(), 0);
      while (q.size() > 0) begin
         mon_e = q.pop_front();
         $display("FAIL missing_pulse: got none want rel=%0d at edge %0d", mon_e.rel, mon_e.at);
         errors++;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
